// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86-64 pipeline constants (icodes, ALU and condition
//                function codes, status codes, register ids) plus small
//                helpers used by the pipeline stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;   // also cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ALU function codes
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    // Condition function codes (jXX / cmovXX)
    localparam logic [3:0] C_YES    = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    // Stage status codes
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;

    localparam logic [3:0] RNONE    = 4'hF;

    // True for the statuses that freeze architectural state downstream.
    function automatic logic stat_is_exc(input logic [2:0] stat);
        return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
    endfunction

    // Condition evaluation; cc is packed {ZF,SF,OF}.
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf, sf, of;
        logic res;
        zf  = cc[2];
        sf  = cc[1];
        of  = cc[0];
        res = 1'b0;
        case (ifun)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : e_stage_if
//  Description : Execute-stage bus: E pipeline register contents in, M pipeline
//                register contents, forwarding pair and CC register out.
//  Ports (as seen from the stage, modport slave):
//    in  : e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM,
//          m_bubble, mem_stat, wb_stat
//    out : x_valE, x_dstE, m_stat, m_icode, m_cnd, m_valE, m_valA, m_dstE,
//          m_dstM, cc_out
//  Revision    : 1.0 - initial release
// ============================================================================
interface e_stage_if #(
    parameter int W = 64
);
    logic [2:0]   e_stat;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] e_valC;
    logic [W-1:0] e_valA;
    logic [W-1:0] e_valB;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic         m_bubble;
    logic [2:0]   mem_stat;
    logic [2:0]   wb_stat;

    logic [W-1:0] x_valE;
    logic [3:0]   x_dstE;
    logic [2:0]   m_stat;
    logic [3:0]   m_icode;
    logic         m_cnd;
    logic [W-1:0] m_valE;
    logic [W-1:0] m_valA;
    logic [3:0]   m_dstE;
    logic [3:0]   m_dstM;
    logic [2:0]   cc_out;

    // Pipeline control / upstream side
    modport master (
        output e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM,
               m_bubble, mem_stat, wb_stat,
        input  x_valE, x_dstE, m_stat, m_icode, m_cnd, m_valE, m_valA, m_dstE,
               m_dstM, cc_out
    );

    // Execute stage side
    modport slave (
        input  e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM,
               m_bubble, mem_stat, wb_stat,
        output x_valE, x_dstE, m_stat, m_icode, m_cnd, m_valE, m_valA, m_dstE,
               m_dstM, cc_out
    );
endinterface
`default_nettype wire

// File: rtl/y86_alu.sv
`default_nettype none
// ============================================================================
//  Module      : y86_alu
//  Description : Combinational Y86-64 ALU, valE = B op A, with ZF/SF/OF.
//  Ports       : alu_a_i, alu_b_i (W) operands; alufun_i (4) op select;
//                val_e_o (W) result; flags_o (3) {ZF,SF,OF}
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] alu_a_i,
    input  logic [W-1:0] alu_b_i,
    input  logic [3:0]   alufun_i,
    output logic [W-1:0] val_e_o,
    output logic [2:0]   flags_o
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic         of;

    assign sum  = alu_b_i + alu_a_i;
    assign diff = alu_b_i - alu_a_i;

    always_comb begin
        val_e_o = '0;
        of      = 1'b0;
        case (alufun_i)
            ALU_ADD: begin
                val_e_o = sum;
                of      = (alu_a_i[W-1] == alu_b_i[W-1]) && (sum[W-1] != alu_a_i[W-1]);
            end
            ALU_SUB: begin
                val_e_o = diff;
                of      = (alu_a_i[W-1] != alu_b_i[W-1]) && (diff[W-1] != alu_b_i[W-1]);
            end
            ALU_AND: val_e_o = alu_b_i & alu_a_i;
            ALU_XOR: val_e_o = alu_b_i ^ alu_a_i;
            // Undefined OPq functions are already flagged INS in decode.
            default: val_e_o = '0;
        endcase
    end

    assign flags_o = {(val_e_o == '0), val_e_o[W-1], of};

endmodule
`default_nettype wire

// File: rtl/e_stage.sv
`default_nettype none
// ============================================================================
//  Module      : e_stage
//  Description : Y86-64 Execute stage: operand selection, ALU, condition-code
//                register, jXX/cmovXX condition, forwarding pair and the
//                M pipeline register.
//  Ports       : clk, rst_n (async, active low); bus (e_stage_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module e_stage
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    e_stage_if.slave    bus
);

    localparam logic [W-1:0] C_EIGHT     = W'(8);
    localparam logic [W-1:0] C_NEG_EIGHT = ~C_EIGHT + W'(1);
    localparam logic [2:0]   C_CC_RESET  = 3'b100;   // ZF=1, SF=0, OF=0

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alufun;
    logic [W-1:0] alu_val;
    logic [2:0]   new_flags;
    logic         set_cc;
    logic         cnd;
    logic [3:0]   dst_e;

    logic [2:0]   cc_q, cc_d;
    logic [2:0]   m_stat_q;
    logic [3:0]   m_icode_q;
    logic         m_cnd_q;
    logic [W-1:0] m_val_e_q;
    logic [W-1:0] m_val_a_q;
    logic [3:0]   m_dst_e_q;
    logic [3:0]   m_dst_m_q;

    // Operand selection
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (bus.e_icode)
            I_RRMOVQ, I_OPQ:               alu_a = bus.e_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:  alu_a = bus.e_valC;
            I_CALL, I_PUSHQ:               alu_a = C_NEG_EIGHT;
            I_RET, I_POPQ:                 alu_a = C_EIGHT;
            default:                       alu_a = '0;
        endcase
        case (bus.e_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_PUSHQ, I_RET, I_POPQ:        alu_b = bus.e_valB;
            default:                       alu_b = '0;
        endcase
    end

    assign alufun = (bus.e_icode == I_OPQ) ? bus.e_ifun : ALU_ADD;

    y86_alu #(.W(W)) u_alu (
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .alufun_i (alufun),
        .val_e_o  (alu_val),
        .flags_o  (new_flags)
    );

    // An exception already in Memory or Writeback must not see CC change.
    assign set_cc = (bus.e_icode == I_OPQ) &&
                    !stat_is_exc(bus.mem_stat) && !stat_is_exc(bus.wb_stat);

    // Condition is judged against the CC held now, not this op's flags.
    assign cnd   = cond_eval(bus.e_ifun, cc_q);
    assign dst_e = ((bus.e_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.e_dstE;
    assign cc_d  = set_cc ? new_flags : cc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q      <= C_CC_RESET;
            m_stat_q  <= S_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_val_e_q <= '0;
            m_val_a_q <= '0;
            m_dst_e_q <= RNONE;
            m_dst_m_q <= RNONE;
        end else begin
            cc_q <= cc_d;
            if (bus.m_bubble) begin
                m_stat_q  <= S_AOK;
                m_icode_q <= I_NOP;
                m_cnd_q   <= 1'b0;
                m_val_e_q <= '0;
                m_val_a_q <= '0;
                m_dst_e_q <= RNONE;
                m_dst_m_q <= RNONE;
            end else begin
                m_stat_q  <= bus.e_stat;
                m_icode_q <= bus.e_icode;
                m_cnd_q   <= cnd;
                m_val_e_q <= alu_val;
                m_val_a_q <= bus.e_valA;
                m_dst_e_q <= dst_e;
                m_dst_m_q <= bus.e_dstM;
            end
        end
    end

    assign bus.x_valE  = alu_val;
    assign bus.x_dstE  = dst_e;
    assign bus.m_stat  = m_stat_q;
    assign bus.m_icode = m_icode_q;
    assign bus.m_cnd   = m_cnd_q;
    assign bus.m_valE  = m_val_e_q;
    assign bus.m_valA  = m_val_a_q;
    assign bus.m_dstE  = m_dst_e_q;
    assign bus.m_dstM  = m_dst_m_q;
    assign bus.cc_out  = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_e_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e_stage
//  Description : Self-checking bench for e_stage: reference model of the
//                Execute stage plus directed vectors with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_e_stage;
    import y86_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    e_stage_if #(.W(64)) bus();

    e_stage #(.W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] vale;
        logic [2:0]  flags;
        logic        cnd;
        logic [3:0]  dste;
        logic        setcc;
    } res_t;

    function automatic res_t model(input logic [3:0] ic, input logic [3:0] ifn,
                                   input logic [63:0] c, input logic [63:0] a,
                                   input logic [63:0] b, input logic [3:0] de,
                                   input logic [2:0] ms, input logic [2:0] ws,
                                   input logic [2:0] cc);
        res_t             r;
        logic [63:0]      oa, ob;
        logic signed [64:0] wide;
        logic             ovf, cz, cs, co;
        logic [3:0]       op;
        r    = '0;
        oa   = '0;
        ob   = '0;
        wide = '0;
        ovf  = 1'b0;
        if (ic == I_RRMOVQ || ic == I_OPQ)                    oa = a;
        else if (ic inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ})    oa = c;
        else if (ic inside {I_CALL, I_PUSHQ})                 oa = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (ic inside {I_RET, I_POPQ})                   oa = 64'd8;
        if (ic inside {I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ}) ob = b;
        op = (ic == I_OPQ) ? ifn : 4'd0;
        // Signed overflow: the 65-bit exact result does not fit in 64 bits.
        case (op)
            4'd0: begin
                wide   = $signed({ob[63], ob}) + $signed({oa[63], oa});
                r.vale = wide[63:0];
                ovf    = (wide[64] != wide[63]);
            end
            4'd1: begin
                wide   = $signed({ob[63], ob}) - $signed({oa[63], oa});
                r.vale = wide[63:0];
                ovf    = (wide[64] != wide[63]);
            end
            4'd2:    r.vale = oa & ob;
            4'd3:    r.vale = oa ^ ob;
            default: r.vale = 64'd0;
        endcase
        r.flags = {(r.vale == 64'd0), r.vale[63], ovf};
        cz = cc[2];
        cs = cc[1];
        co = cc[0];
        case (ifn)
            4'd0:    r.cnd = 1'b1;
            4'd1:    r.cnd = (cs != co) || cz;
            4'd2:    r.cnd = (cs != co);
            4'd3:    r.cnd = cz;
            4'd4:    r.cnd = !cz;
            4'd5:    r.cnd = (cs == co);
            4'd6:    r.cnd = (cs == co) && !cz;
            default: r.cnd = 1'b0;
        endcase
        r.dste  = (ic == I_RRMOVQ && !r.cnd) ? 4'hF : de;
        r.setcc = (ic == I_OPQ) && !(ms inside {3'd2, 3'd3, 3'd4}) && !(ws inside {3'd2, 3'd3, 3'd4});
        return r;
    endfunction

    logic [2:0]  mcc;
    logic [2:0]  exp_stat;
    logic [3:0]  exp_icode;
    logic        exp_cnd;
    logic [63:0] exp_vale;
    logic [63:0] exp_vala;
    logic [3:0]  exp_dste;
    logic [3:0]  exp_dstm;
    res_t        mr;

    always_comb mr = model(bus.e_icode, bus.e_ifun, bus.e_valC, bus.e_valA, bus.e_valB,
                           bus.e_dstE, bus.mem_stat, bus.wb_stat, mcc);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcc       <= 3'b100;
            exp_stat  <= 3'd1;
            exp_icode <= 4'd1;
            exp_cnd   <= 1'b0;
            exp_vale  <= 64'd0;
            exp_vala  <= 64'd0;
            exp_dste  <= 4'hF;
            exp_dstm  <= 4'hF;
        end else begin
            if (mr.setcc) mcc <= mr.flags;
            if (bus.m_bubble) begin
                exp_stat  <= 3'd1;
                exp_icode <= 4'd1;
                exp_cnd   <= 1'b0;
                exp_vale  <= 64'd0;
                exp_vala  <= 64'd0;
                exp_dste  <= 4'hF;
                exp_dstm  <= 4'hF;
            end else begin
                exp_stat  <= bus.e_stat;
                exp_icode <= bus.e_icode;
                exp_cnd   <= mr.cnd;
                exp_vale  <= mr.vale;
                exp_vala  <= bus.e_valA;
                exp_dste  <= mr.dste;
                exp_dstm  <= bus.e_dstM;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("x_valE",  bus.x_valE,  mr.vale);
            chk("x_dstE",  {60'd0, bus.x_dstE},  {60'd0, mr.dste});
            chk("m_stat",  {61'd0, bus.m_stat},  {61'd0, exp_stat});
            chk("m_icode", {60'd0, bus.m_icode}, {60'd0, exp_icode});
            chk("m_cnd",   {63'd0, bus.m_cnd},   {63'd0, exp_cnd});
            chk("m_valE",  bus.m_valE,  exp_vale);
            chk("m_valA",  bus.m_valA,  exp_vala);
            chk("m_dstE",  {60'd0, bus.m_dstE},  {60'd0, exp_dste});
            chk("m_dstM",  {60'd0, bus.m_dstM},  {60'd0, exp_dstm});
            chk("cc_out",  {61'd0, bus.cc_out},  {61'd0, mcc});
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic [3:0] ic, input logic [3:0] ifn, input logic [63:0] c,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] de, input logic [3:0] dm);
        bus.e_stat   = S_AOK;
        bus.e_icode  = ic;
        bus.e_ifun   = ifn;
        bus.e_valC   = c;
        bus.e_valA   = a;
        bus.e_valB   = b;
        bus.e_dstE   = de;
        bus.e_dstM   = dm;
        bus.m_bubble = 1'b0;
        bus.mem_stat = S_AOK;
        bus.wb_stat  = S_AOK;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(I_NOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_icode", {60'd0, bus.m_icode}, 64'd1);
        chk("rst_m_stat",  {61'd0, bus.m_stat},  64'd1);
        chk("rst_m_dstE",  {60'd0, bus.m_dstE},  64'hF);
        chk("rst_cc",      {61'd0, bus.cc_out},  64'b100);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // ADD overflow into the sign bit
        apply(I_OPQ, ALU_ADD, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd3, RNONE);
        tick();
        chk("add_valE", bus.m_valE, 64'h8000_0000_0000_0000);
        chk("add_cc",   {61'd0, bus.cc_out}, 64'b011);

        // SUB to zero, then cmovE taken
        apply(I_OPQ, ALU_SUB, 64'd0, 64'd5, 64'd5, 4'd4, RNONE);
        tick();
        chk("sub_valE", bus.m_valE, 64'd0);
        chk("sub_cc",   {61'd0, bus.cc_out}, 64'b100);
        apply(I_RRMOVQ, C_E, 64'd0, 64'h55, 64'd0, 4'd2, RNONE);
        tick();
        chk("cmove_dstE", {60'd0, bus.m_dstE}, 64'd2);
        chk("cmove_cnd",  {63'd0, bus.m_cnd},  64'd1);
        chk("cmove_valE", bus.m_valE, 64'h55);

        // cmovNE not taken: destination suppressed
        apply(I_RRMOVQ, C_NE, 64'd0, 64'h66, 64'd0, 4'd3, RNONE);
        #1;
        chk("cmovne_xdstE", {60'd0, bus.x_dstE}, 64'hF);
        tick();
        chk("cmovne_dstE", {60'd0, bus.m_dstE}, 64'hF);
        chk("cmovne_cnd",  {63'd0, bus.m_cnd},  64'd0);

        // Stack pointer arithmetic, CC untouched
        apply(I_PUSHQ, 4'd0, 64'd0, 64'hAA, 64'h100, 4'd4, RNONE);
        tick();
        chk("push_valE", bus.m_valE, 64'hF8);
        chk("push_cc",   {61'd0, bus.cc_out}, 64'b100);
        apply(I_POPQ, 4'd0, 64'd0, 64'd0, 64'h100, 4'd4, 4'd0);
        tick();
        chk("pop_valE", bus.m_valE, 64'h108);
        chk("pop_dstM", {60'd0, bus.m_dstM}, 64'd0);

        // Exception in Memory gates CC
        apply(I_OPQ, ALU_ADD, 64'd0, 64'd1, 64'd1, 4'd5, RNONE);
        bus.mem_stat = S_ADR;
        tick();
        chk("memadr_cc",   {61'd0, bus.cc_out}, 64'b100);
        chk("memadr_valE", bus.m_valE, 64'd2);

        // Bubble with gated CC
        apply(I_OPQ, ALU_SUB, 64'd0, 64'd1, 64'd0, 4'd5, RNONE);
        bus.mem_stat = S_ADR;
        bus.m_bubble = 1'b1;
        tick();
        chk("bub_icode", {60'd0, bus.m_icode}, 64'd1);
        chk("bub_stat",  {61'd0, bus.m_stat},  64'd1);
        chk("bub_cc",    {61'd0, bus.cc_out},  64'b100);

        // Bubble while CC updates: 0-1 = -1 -> SF
        apply(I_OPQ, ALU_SUB, 64'd0, 64'd1, 64'd0, 4'd5, RNONE);
        bus.m_bubble = 1'b1;
        tick();
        chk("bubcc_icode", {60'd0, bus.m_icode}, 64'd1);
        chk("bubcc_cc",    {61'd0, bus.cc_out},  64'b010);

        // Halt in Writeback gates CC
        apply(I_OPQ, ALU_AND, 64'd0, 64'hF0, 64'h0F, 4'd6, RNONE);
        bus.wb_stat = S_HLT;
        tick();
        chk("wbhlt_valE", bus.m_valE, 64'd0);
        chk("wbhlt_cc",   {61'd0, bus.cc_out}, 64'b010);

        // SUB negative overflow
        apply(I_OPQ, ALU_SUB, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'd6, RNONE);
        tick();
        chk("subovf_valE", bus.m_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("subovf_cc",   {61'd0, bus.cc_out}, 64'b001);

        // Jumps against {ZF=0,SF=0,OF=1}
        apply(I_JXX, C_L, 64'h400, 64'd0, 64'd0, RNONE, RNONE);
        tick();
        chk("jl_cnd", {63'd0, bus.m_cnd}, 64'd1);
        apply(I_JXX, C_E, 64'h400, 64'd0, 64'd0, RNONE, RNONE);
        tick();
        chk("je_cnd", {63'd0, bus.m_cnd}, 64'd0);
        apply(I_JXX, C_G, 64'h400, 64'd0, 64'd0, RNONE, RNONE);
        tick();
        chk("jg_cnd", {63'd0, bus.m_cnd}, 64'd0);

        // XOR, then undefined OPq function with INS status passing through
        apply(I_OPQ, ALU_XOR, 64'd0, 64'hFF, 64'h0F, 4'd1, RNONE);
        tick();
        chk("xor_valE", bus.m_valE, 64'hF0);
        chk("xor_cc",   {61'd0, bus.cc_out}, 64'b000);
        apply(I_OPQ, 4'd5, 64'd0, 64'h12, 64'h34, 4'd1, RNONE);
        bus.e_stat = S_INS;
        tick();
        chk("badop_valE", bus.m_valE, 64'd0);
        chk("badop_stat", {61'd0, bus.m_stat}, 64'd4);
        chk("badop_cc",   {61'd0, bus.cc_out}, 64'b100);

        // Memory address arithmetic
        apply(I_IRMOVQ, 4'd0, 64'h1234, 64'd0, 64'h999, 4'd7, RNONE);
        tick();
        chk("irmov_valE", bus.m_valE, 64'h1234);
        apply(I_MRMOVQ, 4'd0, 64'd8, 64'd0, 64'h200, RNONE, 4'd2);
        tick();
        chk("mrmov_valE", bus.m_valE, 64'h208);
        apply(I_CALL, 4'd0, 64'h800, 64'h3C, 64'h200, 4'd4, RNONE);
        tick();
        chk("call_valE", bus.m_valE, 64'h1F8);
        chk("call_valA", bus.m_valA, 64'h3C);

        // Asynchronous reset mid-cycle
        apply(I_OPQ, ALU_SUB, 64'd0, 64'd3, 64'd1, 4'd2, RNONE);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_icode", {60'd0, bus.m_icode}, 64'd1);
        chk("arst_dstE",  {60'd0, bus.m_dstE},  64'hF);
        chk("arst_cc",    {61'd0, bus.cc_out},  64'b100);
        tick();
        rst_n = 1'b1;

        apply(I_OPQ, ALU_ADD, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd2, RNONE);
        tick();
        chk("post_valE", bus.m_valE, 64'd0);
        chk("post_cc",   {61'd0, bus.cc_out}, 64'b100);
        apply(I_RET, 4'd0, 64'd0, 64'd0, 64'h1F8, 4'd4, RNONE);
        tick();
        chk("ret_valE", bus.m_valE, 64'h200);
        apply(I_NOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
        tick();
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
